// File: rtl/adc_pkg.sv
// Shared types and helpers for the ADC capture front end.
package adc_pkg;

   localparam int DEF_DATA_WIDTH = 14;
   localparam int DEF_CNT_WIDTH  = 16;

   typedef enum logic [1:0] {
      IDLE,
      CAPTURE,
      DONE
   } state_t;

   // Offset-binary to two's complement is a flip of the sample MSB; en=0 passes raw.
   function automatic logic [31:0] ob_to_tc(input logic [31:0] raw,
                                            input int unsigned msb,
                                            input logic en);
      logic [31:0] mask;
      mask = 32'(en) << msb;
      return raw ^ mask;
   endfunction

endpackage

// File: rtl/adc_clk_gen.sv
// Free-running conversion clock divider: 50% duty adc_clk and a sample strobe
// on the last cycle of each conversion period.
module adc_clk_gen #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst_n,
   output logic adc_clk,
   output logic stb
);

   localparam int CW = $clog2(CLK_DIV);

   logic [CW-1:0] div_cnt;
   logic [CW-1:0] div_nxt;

   always_comb begin
      div_nxt = (div_cnt == CW'(CLK_DIV - 1)) ? '0 : div_cnt + CW'(1);
   end

   // adc_clk is registered from the next count so it tracks div_cnt in the same cycle
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         div_cnt <= '0;
         adc_clk <= 1'b0;
      end else begin
         div_cnt <= div_nxt;
         adc_clk <= (div_nxt >= CW'(CLK_DIV / 2));
      end
   end

   assign stb = (div_cnt == CW'(CLK_DIV - 1));

endmodule

// File: rtl/adc_capture.sv
// ADC capture: registers each conversion, converts to two's complement and
// writes bursts into the sample FIFO, dropping and counting samples when full.
module adc_capture
   import adc_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int CLK_DIV    = 4,
   parameter int BURST_LEN  = 1024,
   parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
   parameter int TWOS_COMP  = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  abort,
   input  logic [DATA_WIDTH-1:0] adc_data,
   input  logic                  adc_otr,
   input  logic                  fifo_full,
   output logic                  adc_clk,
   output logic                  wr_en,
   output logic [DATA_WIDTH-1:0] wr_data,
   output logic                  busy,
   output logic                  done,
   output logic                  otr_flag,
   output logic [CNT_WIDTH-1:0]  ovf_cnt
);

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      return (&v) ? v : v + CNT_WIDTH'(1);
   endfunction

   state_t                state;
   state_t                state_nxt;
   logic                  stb_p0;
   logic                  vld_p1;
   logic [DATA_WIDTH-1:0] wr_data_p1;
   logic [CNT_WIDTH-1:0]  sample_cnt;
   logic [CNT_WIDTH-1:0]  ovf_cnt_r;
   logic                  otr_flag_r;

   adc_clk_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_clk_gen (
      .clk     (clk),
      .rst_n   (rst_n),
      .adc_clk (adc_clk),
      .stb     (stb_p0)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (start) state_nxt = CAPTURE;
         end
         CAPTURE: begin
            if (abort) begin
               state_nxt = IDLE;
            end else if ((BURST_LEN != 0) && (sample_cnt == CNT_WIDTH'(BURST_LEN))) begin
               state_nxt = DONE;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Stage p0 -> p1: strobe cycle registers the sample; write follows one cycle later
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         vld_p1     <= 1'b0;
         wr_data_p1 <= '0;
         sample_cnt <= '0;
         ovf_cnt_r  <= '0;
         otr_flag_r <= 1'b0;
      end else begin
         state  <= state_nxt;
         vld_p1 <= stb_p0 && (state == CAPTURE) && !fifo_full;
         if (stb_p0) begin
            wr_data_p1 <= DATA_WIDTH'(ob_to_tc(32'(adc_data), DATA_WIDTH - 1, TWOS_COMP != 0));
         end
         if ((state == IDLE) && start) begin
            sample_cnt <= '0;
            ovf_cnt_r  <= '0;
            otr_flag_r <= 1'b0;
         end else if ((state == CAPTURE) && stb_p0) begin
            sample_cnt <= sample_cnt + CNT_WIDTH'(1);
            if (fifo_full) ovf_cnt_r <= sat_inc(ovf_cnt_r);
            if (adc_otr)   otr_flag_r <= 1'b1;
         end
      end
   end

   assign wr_en    = vld_p1;
   assign wr_data  = wr_data_p1;
   assign busy     = (state == CAPTURE);
   assign done     = (state == DONE);
   assign otr_flag = otr_flag_r;
   assign ovf_cnt  = ovf_cnt_r;

endmodule

// File: tb/tb_adc_capture.sv
// Directed bench for adc_capture: burst (A) and continuous/raw/narrow-counter (B) instances.
module tb_adc_capture;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        start_a, abort_a, otr_a, full_a;
   logic [13:0] adc_data_a;
   logic        adc_clk_a, wr_en_a, busy_a, done_a, otr_flag_a;
   logic [13:0] wr_data_a;
   logic [15:0] ovf_a;

   logic        start_b, abort_b, otr_b, full_b;
   logic [13:0] adc_data_b;
   logic        adc_clk_b, wr_en_b, busy_b, done_b, otr_flag_b;
   logic [13:0] wr_data_b;
   logic [3:0]  ovf_b;

   int checks   = 0;
   int failures = 0;

   adc_capture #(
      .DATA_WIDTH (14), .CLK_DIV (4), .BURST_LEN (8), .CNT_WIDTH (16), .TWOS_COMP (1)
   ) dut_a (
      .clk (clk), .rst_n (rst_n), .start (start_a), .abort (abort_a),
      .adc_data (adc_data_a), .adc_otr (otr_a), .fifo_full (full_a),
      .adc_clk (adc_clk_a), .wr_en (wr_en_a), .wr_data (wr_data_a),
      .busy (busy_a), .done (done_a), .otr_flag (otr_flag_a), .ovf_cnt (ovf_a)
   );

   adc_capture #(
      .DATA_WIDTH (14), .CLK_DIV (4), .BURST_LEN (0), .CNT_WIDTH (4), .TWOS_COMP (0)
   ) dut_b (
      .clk (clk), .rst_n (rst_n), .start (start_b), .abort (abort_b),
      .adc_data (adc_data_b), .adc_otr (otr_b), .fifo_full (full_b),
      .adc_clk (adc_clk_b), .wr_en (wr_en_b), .wr_data (wr_data_b),
      .busy (busy_b), .done (done_b), .otr_flag (otr_flag_b), .ovf_cnt (ovf_b)
   );

   // Expected divider phase: 0 after reset, wraps at CLK_DIV-1; 3 marks a strobe cycle
   int tb_ph = 0;
   always @(posedge clk) begin
      if (!rst_n) tb_ph <= 0;
      else        tb_ph <= (tb_ph == 3) ? 0 : tb_ph + 1;
   end

   int wr_cnt_a = 0, done_cnt_a = 0, b2b_a = 0;
   int wr_cnt_b = 0, done_cnt_b = 0, b2b_b = 0;
   logic prev_a = 1'b0, prev_b = 1'b0;
   always @(negedge clk) begin
      if (wr_en_a) wr_cnt_a++;
      if (done_a)  done_cnt_a++;
      if (wr_en_a && prev_a) b2b_a++;
      prev_a = wr_en_a;
      if (wr_en_b) wr_cnt_b++;
      if (done_b)  done_cnt_b++;
      if (wr_en_b && prev_b) b2b_b++;
      prev_b = wr_en_b;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic to_phase(input int ph);
      for (int i = 0; i < 8 && tb_ph != ph; i++) tick();
   endtask

   // Drive one sample on the next strobe cycle; returns in the cycle after the strobe
   task automatic sample(input bit sel, input logic [13:0] d, input logic full,
                         input logic otr, input logic abt);
      to_phase(3);
      if (!sel) begin
         adc_data_a = d; full_a = full; otr_a = otr; abort_a = abt;
      end else begin
         adc_data_b = d; full_b = full; otr_b = otr; abort_b = abt;
      end
      tick();
      adc_data_a = 14'h3FFF; full_a = 1'b0; otr_a = 1'b0; abort_a = 1'b0;
      adc_data_b = 14'h3FFF; full_b = 1'b0; otr_b = 1'b0; abort_b = 1'b0;
   endtask

   task automatic start_burst(input bit sel, input logic with_abort);
      to_phase(0);
      if (!sel) begin start_a = 1'b1; abort_a = with_abort; end
      else      begin start_b = 1'b1; abort_b = with_abort; end
      tick();
      start_a = 1'b0; abort_a = 1'b0; start_b = 1'b0; abort_b = 1'b0;
   endtask

   // Eight-sample burst on A with ramp data 0..7; masks select full/otr per sample
   task automatic burst_a(input string tag, input logic [7:0] full_m, input logic [7:0] otr_m);
      int w0, d0, nfull;
      w0 = wr_cnt_a; d0 = done_cnt_a; nfull = 0;
      start_burst(0, 1'b0);
      check({tag, "_busy_rise"}, busy_a, 1);
      check({tag, "_otr_clr"}, otr_flag_a, 0);
      check({tag, "_ovf_clr"}, ovf_a, 0);
      for (int k = 0; k < 8; k++) begin
         sample(0, 14'(k), full_m[k], otr_m[k], 1'b0);
         check($sformatf("%s_wr_en%0d", tag, k), wr_en_a, !full_m[k]);
         if (!full_m[k]) check($sformatf("%s_wr_data%0d", tag, k), wr_data_a, 32'h2000 + k);
         else            nfull++;
         if (k < 7) check($sformatf("%s_no_done%0d", tag, k), done_a, 0);
      end
      tick();
      check({tag, "_done"}, done_a, 1);
      check({tag, "_busy_fall"}, busy_a, 0);
      check({tag, "_wr_off"}, wr_en_a, 0);
      tick();
      check({tag, "_done_1cyc"}, done_a, 0);
      check({tag, "_writes"}, wr_cnt_a - w0, 8 - nfull);
      check({tag, "_done_cnt"}, done_cnt_a - d0, 1);
      check({tag, "_ovf"}, ovf_a, nfull);
      check({tag, "_otr_flag"}, otr_flag_a, |otr_m);
   endtask

   initial begin
      int hi, w0, d0;
      rst_n = 1'b0;
      start_a = 0; abort_a = 0; otr_a = 0; full_a = 0; adc_data_a = 14'h3FFF;
      start_b = 0; abort_b = 0; otr_b = 0; full_b = 0; adc_data_b = 14'h3FFF;
      tick(); tick();
      check("rst_adc_clk", adc_clk_a, 0);
      check("rst_wr_en", wr_en_a, 0);
      check("rst_wr_data", wr_data_a, 0);
      check("rst_busy", busy_a, 0);
      check("rst_done", done_a, 0);
      check("rst_otr", otr_flag_a, 0);
      check("rst_ovf", ovf_a, 0);
      rst_n = 1'b1;

      // Idle: divider runs at 50% duty, strobes never write
      hi = 0;
      for (int i = 0; i < 8; i++) begin tick(); if (adc_clk_a) hi++; end
      check("idle_duty", hi, 4);
      check("idle_no_write", wr_cnt_a, 0);

      burst_a("b1", 8'b0000_0000, 8'b0000_0000);
      burst_a("b2", 8'b0001_1100, 8'b0000_0010);

      // Mid-burst reset on a strobe cycle: in-flight write discarded
      w0 = wr_cnt_a; d0 = done_cnt_a;
      start_burst(0, 1'b0);
      check("b3_otr_clr", otr_flag_a, 0);
      check("b3_ovf_clr", ovf_a, 0);
      for (int k = 0; k < 3; k++) sample(0, 14'(k), 1'b0, 1'b1, 1'b0);
      check("b3_otr_set", otr_flag_a, 1);
      to_phase(3);
      adc_data_a = 14'h0005;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("mrst_wr_en", wr_en_a, 0);
      check("mrst_wr_data", wr_data_a, 0);
      check("mrst_busy", busy_a, 0);
      check("mrst_done", done_a, 0);
      check("mrst_otr", otr_flag_a, 0);
      check("mrst_ovf", ovf_a, 0);
      check("mrst_adc_clk", adc_clk_a, 0);
      for (int i = 0; i < 8; i++) tick();
      check("mrst_writes", wr_cnt_a - w0, 3);
      check("mrst_no_done", done_cnt_a - d0, 0);

      burst_a("b4", 8'b0000_0000, 8'b0000_0000);

      // Abort coinciding with the final strobe: write still issued, no done
      w0 = wr_cnt_a; d0 = done_cnt_a;
      start_burst(0, 1'b0);
      for (int k = 0; k < 7; k++) sample(0, 14'(k), 1'b0, 1'b0, 1'b0);
      sample(0, 14'd7, 1'b0, 1'b0, 1'b1);
      check("abtlast_wr_en", wr_en_a, 1);
      check("abtlast_wr_data", wr_data_a, 32'h2007);
      check("abtlast_busy", busy_a, 0);
      for (int i = 0; i < 6; i++) tick();
      check("abtlast_writes", wr_cnt_a - w0, 8);
      check("abtlast_no_done", done_cnt_a - d0, 0);

      // Continuous mode, raw data, start+abort together in IDLE
      start_burst(1, 1'b1);
      check("cont_start_wins", busy_b, 1);
      sample(1, 14'h1FFF, 1'b0, 1'b0, 1'b0);
      check("raw_wr_en", wr_en_b, 1);
      check("raw_wr_data", wr_data_b, 32'h1FFF);
      for (int k = 1; k < 20; k++) sample(1, 14'(k), 1'b0, 1'b0, 1'b0);
      check("cont_last_data", wr_data_b, 32'h0013);
      check("cont_busy20", busy_b, 1);
      abort_b = 1'b1;
      tick();
      abort_b = 1'b0;
      check("cont_abort_busy", busy_b, 0);
      for (int i = 0; i < 8; i++) tick();
      check("cont_writes", wr_cnt_b, 20);
      check("cont_no_done", done_cnt_b, 0);

      // Overflow counter saturates instead of wrapping
      start_burst(1, 1'b0);
      check("sat_ovf_clr", ovf_b, 0);
      for (int k = 0; k < 20; k++) sample(1, 14'(k), 1'b1, 1'b0, 1'b0);
      check("sat_ovf", ovf_b, 32'hF);
      check("sat_no_writes", wr_cnt_b, 20);
      check("sat_busy", busy_b, 1);
      abort_b = 1'b1;
      tick();
      abort_b = 1'b0;
      check("sat_abort_busy", busy_b, 0);
      check("sat_ovf_hold", ovf_b, 32'hF);

      check("b2b_a", b2b_a, 0);
      check("b2b_b", b2b_b, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
